// File: rtl/sprite_pkg.sv
// Shared types and helpers for the sprite selector: animation state encoding,
// the decider code arithmetic and a parameter legality check.
package sprite_pkg;

   typedef enum logic [1:0] {
      IDLE,
      WALK,
      HIT
   } anim_state_t;

   // Frame code handed to the sprite ROM: each sprite owns NUM_FRAMES+1 slots.
   function automatic int decider_code(input int layer, input int frame, input int num_frames);
      return layer * (num_frames + 1) + frame;
   endfunction

   function automatic bit cfg_legal(input int num_sprites, input int num_frames,
                                    input int frame_period, input int hit_ticks,
                                    input int dec_w);
      return (num_sprites >= 2) && (num_frames >= 1) && (frame_period >= 1) &&
             (hit_ticks >= 1) && (num_sprites * (num_frames + 1) <= (1 << dec_w));
   endfunction

endpackage

// File: rtl/sprite_anim_fsm.sv
// Per-sprite animation sequencer: idle, walk cycle paced by frame ticks, and a
// timed hit-flash frame that can be retriggered at any cycle.
module sprite_anim_fsm
   import sprite_pkg::*;
#(
   parameter int NUM_FRAMES   = 4,
   parameter int FRAME_PERIOD = 8,
   parameter int HIT_TICKS    = 16,
   parameter int FRAME_W      = $clog2(NUM_FRAMES + 1)
) (
   input  logic               Clk,
   input  logic               Reset_n,
   input  logic               frame_tick,
   input  logic               moving,
   input  logic               hit,
   output logic [FRAME_W-1:0] frame
);

   localparam int PER_W = (FRAME_PERIOD > 1) ? $clog2(FRAME_PERIOD) : 1;
   localparam int HIT_W = $clog2(HIT_TICKS + 1);

   anim_state_t      state;
   logic [PER_W-1:0] period_cnt;
   logic [HIT_W-1:0] hit_cnt;

   // A hit pulse overrides everything, including a coincident frame tick.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state      <= IDLE;
         frame      <= '0;
         period_cnt <= '0;
         hit_cnt    <= '0;
      end else if (hit) begin
         state   <= HIT;
         frame   <= FRAME_W'(NUM_FRAMES);
         hit_cnt <= HIT_W'(HIT_TICKS);
      end else if (frame_tick) begin
         case (state)
            IDLE: begin
               frame      <= '0;
               period_cnt <= '0;
               if (moving) state <= WALK;
            end
            WALK: begin
               if (!moving) begin
                  state      <= IDLE;
                  frame      <= '0;
                  period_cnt <= '0;
               end else if (period_cnt == PER_W'(FRAME_PERIOD - 1)) begin
                  period_cnt <= '0;
                  frame      <= (frame == FRAME_W'(NUM_FRAMES - 1)) ? '0 : frame + 1'b1;
               end else begin
                  period_cnt <= period_cnt + 1'b1;
               end
            end
            HIT: begin
               if (hit_cnt <= HIT_W'(1)) begin
                  hit_cnt    <= '0;
                  state      <= moving ? WALK : IDLE;
                  frame      <= '0;
                  period_cnt <= '0;
               end else begin
                  hit_cnt <= hit_cnt - 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: rtl/sprite_frame_mux.sv
// Per-pixel sprite selector: frame-latched sprite geometry, two-stage hit-test
// and priority pipeline, and one animation sequencer per sprite.
module sprite_frame_mux
   import sprite_pkg::*;
#(
   parameter int NUM_SPRITES  = 3,
   parameter int COORD_W      = 10,
   parameter int NUM_FRAMES   = 4,
   parameter int FRAME_PERIOD = 8,
   parameter int HIT_TICKS    = 16,
   parameter int DEC_W        = 6
) (
   input  logic                             Clk,
   input  logic                             Reset_n,
   input  logic                             frame_tick,
   input  logic [NUM_SPRITES-1:0]           sprite_en,
   input  logic [NUM_SPRITES-1:0]           sprite_moving,
   input  logic [NUM_SPRITES-1:0]           sprite_hit,
   input  logic [NUM_SPRITES*COORD_W-1:0]   sprite_x,
   input  logic [NUM_SPRITES*COORD_W-1:0]   sprite_y,
   input  logic [NUM_SPRITES*COORD_W-1:0]   sprite_size,
   input  logic [COORD_W-1:0]               DrawX,
   input  logic [COORD_W-1:0]               DrawY,
   output logic                             pix_valid,
   output logic [$clog2(NUM_SPRITES)-1:0]   layer_id,
   output logic [COORD_W-1:0]               offset_x,
   output logic [COORD_W-1:0]               offset_y,
   output logic [DEC_W-1:0]                 decider_value
);

   localparam int LAYER_W = $clog2(NUM_SPRITES);
   localparam int FRAME_W = $clog2(NUM_FRAMES + 1);
   localparam int SW      = COORD_W + 2;

   if (!cfg_legal(NUM_SPRITES, NUM_FRAMES, FRAME_PERIOD, HIT_TICKS, DEC_W)) begin : g_bad_cfg
      $error("sprite_frame_mux: illegal parameter combination");
   end

   logic               sh_en   [NUM_SPRITES];
   logic [COORD_W-1:0] sh_x    [NUM_SPRITES];
   logic [COORD_W-1:0] sh_y    [NUM_SPRITES];
   logic [COORD_W-1:0] sh_size [NUM_SPRITES];
   logic [FRAME_W-1:0] frame   [NUM_SPRITES];

   // Geometry only moves on frame boundaries so a frame is never drawn torn.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         for (int i = 0; i < NUM_SPRITES; i++) begin
            sh_en[i]   <= 1'b0;
            sh_x[i]    <= '0;
            sh_y[i]    <= '0;
            sh_size[i] <= '0;
         end
      end else if (frame_tick) begin
         for (int i = 0; i < NUM_SPRITES; i++) begin
            sh_en[i]   <= sprite_en[i];
            sh_x[i]    <= sprite_x[i*COORD_W +: COORD_W];
            sh_y[i]    <= sprite_y[i*COORD_W +: COORD_W];
            sh_size[i] <= sprite_size[i*COORD_W +: COORD_W];
         end
      end
   end

   for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_anim
      sprite_anim_fsm #(
         .NUM_FRAMES  (NUM_FRAMES),
         .FRAME_PERIOD(FRAME_PERIOD),
         .HIT_TICKS   (HIT_TICKS),
         .FRAME_W     (FRAME_W)
      ) u_anim (
         .Clk       (Clk),
         .Reset_n   (Reset_n),
         .frame_tick(frame_tick),
         .moving    (sprite_moving[g]),
         .hit       (sprite_hit[g]),
         .frame     (frame[g])
      );
   end

   logic               hit_c  [NUM_SPRITES];
   logic [COORD_W-1:0] offx_c [NUM_SPRITES];
   logic [COORD_W-1:0] offy_c [NUM_SPRITES];
   logic signed [SW-1:0] px, py, lo_x, hi_x, lo_y, hi_y;

   // Two extra bits keep x-size below zero and x+size past the screen exact.
   always_comb begin
      px   = $signed({2'b00, DrawX});
      py   = $signed({2'b00, DrawY});
      lo_x = '0;
      hi_x = '0;
      lo_y = '0;
      hi_y = '0;
      for (int i = 0; i < NUM_SPRITES; i++) begin
         lo_x      = $signed({2'b00, sh_x[i]}) - $signed({2'b00, sh_size[i]});
         hi_x      = $signed({2'b00, sh_x[i]}) + $signed({2'b00, sh_size[i]});
         lo_y      = $signed({2'b00, sh_y[i]}) - $signed({2'b00, sh_size[i]});
         hi_y      = $signed({2'b00, sh_y[i]}) + $signed({2'b00, sh_size[i]});
         hit_c[i]  = sh_en[i] && (lo_x <= px) && (px <= hi_x) && (lo_y <= py) && (py <= hi_y);
         offx_c[i] = DrawX - sh_x[i] + sh_size[i];
         offy_c[i] = DrawY - sh_y[i] + sh_size[i];
      end
   end

   logic               s1_hit   [NUM_SPRITES];
   logic [COORD_W-1:0] s1_offx  [NUM_SPRITES];
   logic [COORD_W-1:0] s1_offy  [NUM_SPRITES];
   logic [FRAME_W-1:0] s1_frame [NUM_SPRITES];

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         for (int i = 0; i < NUM_SPRITES; i++) begin
            s1_hit[i]   <= 1'b0;
            s1_offx[i]  <= '0;
            s1_offy[i]  <= '0;
            s1_frame[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_SPRITES; i++) begin
            s1_hit[i]   <= hit_c[i];
            s1_offx[i]  <= offx_c[i];
            s1_offy[i]  <= offy_c[i];
            s1_frame[i] <= frame[i];
         end
      end
   end

   logic               win_valid;
   logic [LAYER_W-1:0] win_layer;
   logic [COORD_W-1:0] win_offx, win_offy;
   logic [DEC_W-1:0]   win_dec;

   // Scanning from the top index down lets the lowest covering index win.
   always_comb begin
      win_valid = 1'b0;
      win_layer = '0;
      win_offx  = '0;
      win_offy  = '0;
      win_dec   = '0;
      for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
         if (s1_hit[i]) begin
            win_valid = 1'b1;
            win_layer = LAYER_W'(i);
            win_offx  = s1_offx[i];
            win_offy  = s1_offy[i];
            win_dec   = DEC_W'(decider_code(i, int'(s1_frame[i]), NUM_FRAMES));
         end
      end
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         pix_valid     <= 1'b0;
         layer_id      <= '0;
         offset_x      <= '0;
         offset_y      <= '0;
         decider_value <= '0;
      end else begin
         pix_valid     <= win_valid;
         layer_id      <= win_layer;
         offset_x      <= win_offx;
         offset_y      <= win_offy;
         decider_value <= win_dec;
      end
   end

endmodule

// File: tb/tb_sprite_frame_mux.sv
// Scoreboard bench for sprite_frame_mux: an abstract frame/animation model
// predicts every pixel result, and a monitor compares two cycles later.
module tb_sprite_frame_mux;

   localparam int NS = 3;
   localparam int CW = 10;
   localparam int NF = 4;
   localparam int FP = 8;
   localparam int HT = 16;
   localparam int DW = 6;

   logic             Clk = 1'b0;
   logic             Reset_n;
   logic             frame_tick;
   logic [NS-1:0]    sprite_en, sprite_moving, sprite_hit;
   logic [NS*CW-1:0] sprite_x, sprite_y, sprite_size;
   logic [CW-1:0]    DrawX, DrawY;
   logic             pix_valid;
   logic [1:0]       layer_id;
   logic [CW-1:0]    offset_x, offset_y;
   logic [DW-1:0]    decider_value;

   sprite_frame_mux #(
      .NUM_SPRITES(NS), .COORD_W(CW), .NUM_FRAMES(NF),
      .FRAME_PERIOD(FP), .HIT_TICKS(HT), .DEC_W(DW)
   ) dut (
      .Clk(Clk), .Reset_n(Reset_n), .frame_tick(frame_tick),
      .sprite_en(sprite_en), .sprite_moving(sprite_moving), .sprite_hit(sprite_hit),
      .sprite_x(sprite_x), .sprite_y(sprite_y), .sprite_size(sprite_size),
      .DrawX(DrawX), .DrawY(DrawY), .pix_valid(pix_valid), .layer_id(layer_id),
      .offset_x(offset_x), .offset_y(offset_y), .decider_value(decider_value)
   );

   always #5 Clk = ~Clk;

   typedef struct packed {
      logic          pv;
      logic [1:0]    lay;
      logic [CW-1:0] ox;
      logic [CW-1:0] oy;
      logic [DW-1:0] dec;
   } px_t;

   int  lx [NS], ly [NS], lsz [NS];
   bit  len [NS], lmov [NS];

   always_comb begin
      sprite_x      = '0;
      sprite_y      = '0;
      sprite_size   = '0;
      sprite_en     = '0;
      sprite_moving = '0;
      for (int i = 0; i < NS; i++) begin
         sprite_x[i*CW +: CW]    = CW'(lx[i]);
         sprite_y[i*CW +: CW]    = CW'(ly[i]);
         sprite_size[i*CW +: CW] = CW'(lsz[i]);
         sprite_en[i]            = len[i];
         sprite_moving[i]        = lmov[i];
      end
   end

   // Reference model: latched geometry plus an animation mode per sprite
   // (0 idle, 1 walking for m_walk ticks, 2 flashing for m_hitleft more ticks).
   int m_en [NS], m_x [NS], m_y [NS], m_sz [NS];
   int m_mode [NS], m_walk [NS], m_hitleft [NS];

   px_t      exp_q[$];
   logic     stim_valid = 1'b0;
   logic [1:0] vd = '0;
   int       checks = 0;
   int       errors = 0;

   function automatic int model_frame(input int i);
      if (m_mode[i] == 2) return NF;
      if (m_mode[i] == 1) return (m_walk[i] / FP) % NF;
      return 0;
   endfunction

   function automatic px_t model_pixel(input int dx, input int dy);
      px_t r;
      r = '0;
      for (int i = 0; i < NS; i++) begin
         if (m_en[i] != 0 && dx >= m_x[i] - m_sz[i] && dx <= m_x[i] + m_sz[i] &&
             dy >= m_y[i] - m_sz[i] && dy <= m_y[i] + m_sz[i]) begin
            r.pv  = 1'b1;
            r.lay = 2'(i);
            r.ox  = CW'(dx - (m_x[i] - m_sz[i]));
            r.oy  = CW'(dy - (m_y[i] - m_sz[i]));
            r.dec = DW'(i * (NF + 1) + model_frame(i));
            return r;
         end
      end
      return r;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < NS; i++) begin
         m_en[i] = 0; m_x[i] = 0; m_y[i] = 0; m_sz[i] = 0;
         m_mode[i] = 0; m_walk[i] = 0; m_hitleft[i] = 0;
      end
   endtask

   task automatic model_step(input bit tick, input logic [NS-1:0] hit);
      for (int i = 0; i < NS; i++) begin
         if (hit[i]) begin
            m_mode[i]    = 2;
            m_hitleft[i] = HT;
         end else if (tick) begin
            if (m_mode[i] == 2) begin
               m_hitleft[i]--;
               if (m_hitleft[i] == 0) begin
                  m_mode[i] = lmov[i] ? 1 : 0;
                  m_walk[i] = 0;
               end
            end else if (m_mode[i] == 1) begin
               if (!lmov[i]) m_mode[i] = 0;
               else m_walk[i]++;
            end else if (lmov[i]) begin
               m_mode[i] = 1;
               m_walk[i] = 0;
            end
         end
      end
      if (tick) begin
         for (int i = 0; i < NS; i++) begin
            m_en[i] = len[i] ? 1 : 0;
            m_x[i]  = lx[i] & 1023;
            m_y[i]  = ly[i] & 1023;
            m_sz[i] = lsz[i] & 1023;
         end
      end
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input bit tick, input logic [NS-1:0] hit, input int dx, input int dy);
      frame_tick = tick;
      sprite_hit = hit;
      DrawX      = CW'(dx);
      DrawY      = CW'(dy);
      stim_valid = 1'b1;
      exp_q.push_back(model_pixel(dx & 1023, dy & 1023));
      @(posedge Clk);
      model_step(tick, hit);
      #1;
      frame_tick = 1'b0;
      sprite_hit = '0;
      stim_valid = 1'b0;
   endtask

   task automatic set_sprite(input int i, input bit en, input bit mov, input int x, input int y, input int sz);
      len[i] = en; lmov[i] = mov; lx[i] = x; ly[i] = y; lsz[i] = sz;
   endtask

   task automatic check_zero_outputs(input string tag);
      checkOutput({tag, "_pix_valid"}, 32'(pix_valid), 32'd0);
      checkOutput({tag, "_layer_id"}, 32'(layer_id), 32'd0);
      checkOutput({tag, "_offset_x"}, 32'(offset_x), 32'd0);
      checkOutput({tag, "_offset_y"}, 32'(offset_y), 32'd0);
      checkOutput({tag, "_decider"}, 32'(decider_value), 32'd0);
   endtask

   always @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) vd <= '0;
      else vd <= {vd[0], stim_valid};
   end

   // Monitor: every tracked pixel emerges two edges after it was presented.
   always @(negedge Clk) begin
      if (Reset_n === 1'b1 && vd[1]) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL scoreboard: got output with empty queue, expected a queued entry");
         end else begin
            px_t e, g;
            e = exp_q.pop_front();
            g = {pix_valid, layer_id, offset_x, offset_y, decider_value};
            checkOutput("pixel", 32'(g), 32'(e));
         end
      end
   end

   initial begin
      int j, dx, dy;
      bit tick;
      logic [NS-1:0] hit;

      Reset_n = 1'b0;
      frame_tick = 1'b0; sprite_hit = '0; DrawX = '0; DrawY = '0;
      for (int i = 0; i < NS; i++) set_sprite(i, 0, 0, 0, 0, 0);
      model_reset();
      repeat (3) @(posedge Clk);
      #1;
      check_zero_outputs("reset");
      Reset_n = 1'b1;

      $display("[TB] single sprite edges");
      set_sprite(0, 1, 0, 100, 100, 8);
      for (int x = 90; x <= 110; x += 4) applyStimulus(0, '0, x, 100);
      applyStimulus(1, '0, 0, 0);
      for (int x = 90; x <= 110; x++) applyStimulus(0, '0, x, 100);
      applyStimulus(0, '0, 100, 91);
      applyStimulus(0, '0, 100, 92);
      applyStimulus(0, '0, 100, 108);
      applyStimulus(0, '0, 100, 109);

      $display("[TB] overlap priority");
      set_sprite(0, 1, 0, 200, 200, 5);
      set_sprite(2, 1, 0, 202, 198, 6);
      applyStimulus(1, '0, 0, 0);
      for (int x = 194; x <= 209; x += 3) applyStimulus(0, '0, x, 200);
      len[0] = 0;
      applyStimulus(1, '0, 0, 0);
      for (int x = 194; x <= 209; x += 3) applyStimulus(0, '0, x, 200);

      $display("[TB] walk cycle and hit flash");
      len[2] = 0;
      set_sprite(1, 1, 1, 300, 300, 4);
      applyStimulus(1, '0, 0, 0);
      for (int k = 0; k < 60; k++) begin
         applyStimulus(1, (k == 35) ? 3'b010 : 3'b000, 0, 0);
         applyStimulus(0, '0, 300, 300);
         applyStimulus(0, '0, 298, 303);
      end
      lmov[1] = 0;
      applyStimulus(1, '0, 0, 0);
      applyStimulus(0, '0, 300, 300);

      $display("[TB] left edge and no wrap");
      len[1] = 0;
      set_sprite(0, 1, 0, 3, 50, 8);
      applyStimulus(1, '0, 0, 0);
      for (int x = 0; x <= 12; x++) applyStimulus(0, '0, x, 50);
      applyStimulus(0, '0, 1023, 50);

      $display("[TB] live input ignored until tick");
      lx[0] = 500;
      applyStimulus(0, '0, 3, 50);
      applyStimulus(0, '0, 500, 50);
      applyStimulus(1, '0, 0, 0);
      applyStimulus(0, '0, 3, 50);
      applyStimulus(0, '0, 500, 50);

      $display("[TB] randomized traffic");
      for (int c = 0; c < 1500; c++) begin
         if ($urandom_range(0, 19) == 0) begin
            j = int'($urandom_range(0, NS - 1));
            case ($urandom_range(0, 3))
               0: lx[j] = int'($urandom_range(0, 12));
               1: lx[j] = int'($urandom_range(1005, 1023));
               default: lx[j] = int'($urandom_range(100, 140));
            endcase
            ly[j]  = int'($urandom_range(100, 140));
            lsz[j] = int'($urandom_range(0, 24));
            len[j] = ($urandom_range(0, 3) != 0);
         end
         if ($urandom_range(0, 29) == 0) begin
            j = int'($urandom_range(0, NS - 1));
            lmov[j] = !lmov[j];
         end
         tick = ($urandom_range(0, 2) == 0);
         hit  = '0;
         for (int i = 0; i < NS; i++) if ($urandom_range(0, 59) == 0) hit[i] = 1'b1;
         j  = int'($urandom_range(0, NS - 1));
         dx = lx[j] - lsz[j] - 2 + int'($urandom_range(0, 2 * lsz[j] + 4));
         dy = ly[j] - lsz[j] - 2 + int'($urandom_range(0, 2 * lsz[j] + 4));
         applyStimulus(tick, hit, dx, dy);
      end

      $display("[TB] asynchronous reset mid-line");
      for (int i = 0; i < NS; i++) set_sprite(i, 0, 0, 0, 0, 0);
      set_sprite(0, 1, 1, 400, 400, 10);
      applyStimulus(1, '0, 0, 0);
      for (int k = 0; k < 4; k++) applyStimulus(0, '0, 395 + k, 402);
      #3;
      Reset_n = 1'b0;
      exp_q.delete();
      #1;
      check_zero_outputs("async_reset");
      frame_tick = 1'b1;
      DrawX = 10'd400; DrawY = 10'd400;
      repeat (3) @(posedge Clk);
      #1;
      frame_tick = 1'b0;
      checkOutput("reset_hold_pix_valid", 32'(pix_valid), 32'd0);
      model_reset();
      Reset_n = 1'b1;
      applyStimulus(0, '0, 400, 400);
      applyStimulus(0, '0, 405, 395);
      applyStimulus(1, '0, 0, 0);
      applyStimulus(0, '0, 400, 400);
      applyStimulus(0, '0, 390, 410);
      applyStimulus(0, '0, 389, 400);

      repeat (4) @(posedge Clk);
      #1;
      checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/sprite_frame_mux.md
# sprite_frame_mux

Parametrised per-pixel sprite selector and animation sequencer for the VGA display path. It tracks NUM_SPRITES on-screen entities (player, monsters, items), each with its own animation state machine clocked by a once-per-frame tick. For every DrawX/DrawY it reports which sprite covers the pixel, resolving overlaps by priority, and emits the sprite's current animation frame code to the sprite ROM address logic.

## Interface
- NUM_SPRITES, 3, number of sprite channels; index 0 has highest priority
- COORD_W, 10, width of all coordinate and size values
- NUM_FRAMES, 4, walk-cycle frames per sprite; frame index NUM_FRAMES is the hit-flash frame
- FRAME_PERIOD, 8, frame_tick pulses per walk-frame advance (≥1)
- HIT_TICKS, 16, frame_tick pulses the hit-flash frame is held (≥1)
- DEC_W, 6, width of decider_value; NUM_SPRITES*(NUM_FRAMES+1) ≤ 2^DEC_W is required
- Clk  in  1  system clock; single clock domain
- Reset_n  in  1  asynchronous, active-low reset
- frame_tick  in  1  one-cycle pulse at start of vertical blank
- sprite_en  in  NUM_SPRITES  per-sprite display enable
- sprite_moving  in  NUM_SPRITES  per-sprite "walking" request
- sprite_hit  in  NUM_SPRITES  per-sprite one-cycle hit pulse
- sprite_x, sprite_y  in  NUM_SPRITES×COORD_W (packed)  sprite centre
- sprite_size  in  NUM_SPRITES×COORD_W (packed)  half-extent
- DrawX, DrawY  in  COORD_W  current pixel
- pix_valid  out  1  some enabled sprite covers the pixel
- layer_id  out  $clog2(NUM_SPRITES)  winning sprite index
- offset_x, offset_y  out  COORD_W  DrawX−(x−size), DrawY−(y−size) of the winner
- decider_value  out  DEC_W  layer_id*(NUM_FRAMES+1)+frame of the winner

## Operation
- Shadow registers: en, x, y, size for every sprite are captured only on frame_tick; hit tests use shadow copies only, so no mid-frame tearing. Between ticks, live inputs are ignored.
- Per-sprite FSM, states IDLE, WALK, HIT; transitions evaluated only on frame_tick, except hit.
  - sprite_hit pulse (any cycle): enter HIT, frame=NUM_FRAMES, hit counter=HIT_TICKS; a hit while already in HIT restarts the counter.
  - HIT: each frame_tick decrements counter; at 0 go to WALK if sprite_moving else IDLE, frame=0, period counter=0.
  - IDLE: frame=0; on frame_tick with sprite_moving=1 go to WALK.
  - WALK: period counter increments per frame_tick; on reaching FRAME_PERIOD-1 it clears and frame advances, wrapping NUM_FRAMES-1→0. On frame_tick with sprite_moving=0 go to IDLE, frame=0.
- Hit test: (x−size) ≤ DrawX ≤ (x+size) and same for Y, inclusive; computed signed in COORD_W+2 bits so x<size (left/top edge) and x+size overflow are exact.
- Priority: lowest-index enabled covering sprite wins. No hit: pix_valid=0, layer_id=0, offsets=0, decider_value=0.

## Timing
- Reset: all outputs 0; all FSMs IDLE, frame 0, counters 0; shadow en=0 (nothing displayed until first frame_tick).
- Pixel pipeline latency 2 cycles: DrawX/DrawY at cycle t → outputs valid at t+2 (stage 1 registered per-sprite hit flags and offsets; stage 2 registered priority result). Fully pipelined, one pixel per cycle.
- FSM/frame updates take effect the cycle after frame_tick; pixels entering stage 1 that cycle use the new frame.
- sprite_hit coincident with frame_tick: hit wins; that tick is not counted against HIT_TICKS.
- Reset_n deasserted mid-frame: pipeline flushes to zeros immediately (async); recovery from next frame_tick.

## Structure
- Package sprite_pkg: typedef for FSM state enum (IDLE, WALK, HIT), decider arithmetic helper function, parameter legality checks.
- One sub-module sprite_anim_fsm (one instance per sprite via generate) holding the FSM, period and hit counters; top holds shadow registers, hit test pipeline and priority encoder.

## Test plan
- Reset then frame_tick with sprite0 en, x=100,y=100,size=8: DrawX=92..108, DrawY=100 → pix_valid=1 two cycles later, offset_x=0..16; DrawX=91 and 109 → pix_valid=0.
- Sprites 0 and 2 overlapping at (200,200): layer_id=0, decider_value=0; disable sprite0 at next tick → layer_id=2, decider_value=10.
- sprite1 moving, FRAME_PERIOD=8: frame sequence 0,1,2,3,0 advancing every 8 frame_ticks; decider_value 5,6,7,8,5.
- sprite_hit to sprite1 on same cycle as frame_tick → decider_value=9 for exactly 16 subsequent ticks, then WALK frame 0.
- Sprite at x=3,size=8: DrawX=0..11 hit, DrawX=1023 not hit (no wrap).
- Change sprite_x mid-frame without tick → output unchanged until next frame_tick; assert Reset_n low mid-line → all outputs 0 asynchronously.
